switch_sched_rr: RTL and testbench

- Round-robin crossbar scheduler for the 4-port switch. Replaces the fixed-priority output arbitration between the per-port ingress FIFOs and the four output muxes.
- Each cycle it matches input FIFOs to output ports. Multicast is all-or-nothing, output backpressure is honoured, and starvation is bounded.
- It produces FIFO pop pulses and registered mux selects/actives. Its outputs feed the existing output_mux instances directly.

---
 rtl/switch_sched_rr_pkg.sv | 21 ++
 rtl/switch_sched_rr_wait_ctr.sv | 45 ++++
 rtl/switch_sched_rr.sv | 154 +++++++++++++++
 tb/tb_switch_sched_rr.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_sched_rr_pkg.sv
// -----------------------------------------------------------------------------
// switch_sched_rr_pkg
// Shared constants and types for the 4-port switch crossbar scheduler.
//   NUM_PORTS             number of input and output ports (this revision: 4)
//   ADDR_WIDTH            destination mask width, one bit per output port
//   PORT_IDX_WIDTH        width of a port index
//   STARVE_LIMIT_DEFAULT  blocked cycles before an input is forced to the top
//   CNT_WIDTH_DEFAULT     width of the zero-mask drop counter
// -----------------------------------------------------------------------------
package switch_sched_rr_pkg;

   localparam int NUM_PORTS            = 4;
   localparam int ADDR_WIDTH           = 4;
   localparam int PORT_IDX_WIDTH       = $clog2(NUM_PORTS);
   localparam int STARVE_LIMIT_DEFAULT = 8;
   localparam int CNT_WIDTH_DEFAULT    = 16;

   typedef logic [ADDR_WIDTH-1:0]     port_mask_t;
   typedef logic [PORT_IDX_WIDTH-1:0] port_idx_t;

endpackage

// File: rtl/switch_sched_rr_wait_ctr.sv
// -----------------------------------------------------------------------------
// sched_wait_ctr
// Per-input saturating wait counter. Counts consecutive cycles in which the
// input presents a packet but is not granted; when the count reaches
// STARVE_LIMIT the input is flagged as starving.
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset
//   i_req_valid    input FIFO has a head packet
//   i_grant        input was granted (popped) this cycle
//   o_starve_flag  counter sits at STARVE_LIMIT; driven only by the register
// -----------------------------------------------------------------------------
module sched_wait_ctr
   import switch_sched_rr_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req_valid,
   input  logic i_grant,
   output logic o_starve_flag
);

   localparam int                   CTR_WIDTH = $clog2(STARVE_LIMIT + 1);
   localparam logic [CTR_WIDTH-1:0] LIMIT     = CTR_WIDTH'(STARVE_LIMIT);

   logic [CTR_WIDTH-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (!i_req_valid || i_grant) begin
         r_cnt <= '0;
      end else if (r_cnt != LIMIT) begin
         r_cnt <= r_cnt + CTR_WIDTH'(1);
      end
   end

   // Compare on the registered count: the flag drops the cycle after a grant.
   assign o_starve_flag = (r_cnt == LIMIT);

endmodule

// File: rtl/switch_sched_rr.sv
// -----------------------------------------------------------------------------
// switch_sched_rr
// Round-robin crossbar scheduler for the 4-port switch. Each cycle it matches
// input FIFO heads to output ports (multicast all-or-nothing, output
// backpressure honoured, starvation bounded), pops the matched FIFOs and
// registers the output mux selects one cycle later to line up with the FIFO's
// registered read data.
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset
//   i_req_valid    [i]      FIFO i has a head packet
//   i_req_dst      [4i+3:4i] destination mask of FIFO i head packet
//   i_out_ready    [o]      output o can accept a packet this cycle
//   o_grant        [i]      pop pulse to FIFO i (combinational)
//   o_mux_sel      [2o+1:2o] source input for output o (registered)
//   o_out_active   [o]      output o carries a valid packet (registered)
//   o_starve_flag  [i]      input i in forced-priority mode (registered)
//   o_drop_cnt     saturating count of zero-mask packets dropped (registered)
// -----------------------------------------------------------------------------
module switch_sched_rr
   import switch_sched_rr_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
   parameter int CNT_WIDTH    = CNT_WIDTH_DEFAULT
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_PORTS-1:0]                i_req_valid,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     i_req_dst,
   input  logic [NUM_PORTS-1:0]                i_out_ready,
   output logic [NUM_PORTS-1:0]                o_grant,
   output logic [NUM_PORTS*PORT_IDX_WIDTH-1:0] o_mux_sel,
   output logic [NUM_PORTS-1:0]                o_out_active,
   output logic [NUM_PORTS-1:0]                o_starve_flag,
   output logic [CNT_WIDTH-1:0]                o_drop_cnt
);

   localparam logic [PORT_IDX_WIDTH:0] ONE_DROP = (PORT_IDX_WIDTH+1)'(1);

   // Registered state
   port_idx_t                                 r_rr_ptr;
   logic [NUM_PORTS-1:0][PORT_IDX_WIDTH-1:0]  r_mux_sel;
   port_mask_t                                r_out_active;
   logic [CNT_WIDTH-1:0]                      r_drop_cnt;

   // Matching results
   logic [NUM_PORTS-1:0]                      w_starve_flag;
   port_idx_t                                 w_start;
   port_idx_t                                 w_idx;
   port_mask_t                                w_dst;
   port_mask_t                                w_taken;
   logic [NUM_PORTS-1:0]                      w_grant;
   logic [NUM_PORTS-1:0][PORT_IDX_WIDTH-1:0]  w_src;
   logic                                      w_first_found;
   port_idx_t                                 w_first_idx;
   logic [PORT_IDX_WIDTH:0]                   w_n_drops;
   logic [CNT_WIDTH:0]                        w_drop_sum;

   // --------------------------------------------------------------------------
   // Per-input wait counters
   // --------------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_wait
      sched_wait_ctr #(
         .STARVE_LIMIT (STARVE_LIMIT)
      ) u_wait_ctr (
         .clk           (clk),
         .rst           (rst),
         .i_req_valid   (i_req_valid[gi]),
         .i_grant       (w_grant[gi]),
         .o_starve_flag (w_starve_flag[gi])
      );
   end

   // --------------------------------------------------------------------------
   // Matching
   // --------------------------------------------------------------------------
   // NOTE: every variable written here gets a default before any conditional
   // assignment, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_start       = r_rr_ptr;
      w_idx         = '0;
      w_dst         = '0;
      w_taken       = '0;
      w_grant       = '0;
      w_src         = r_mux_sel;   // untaken outputs hold their select
      w_first_found = 1'b0;
      w_first_idx   = '0;
      w_n_drops     = '0;

      // Lowest-indexed starving input overrides the round-robin pointer.
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (w_starve_flag[k]) begin
            w_start = port_idx_t'(k);
         end
      end

      for (int k = 0; k < NUM_PORTS; k++) begin
         // 2-bit add: the scan wraps from 3 back to 0.
         w_idx = w_start + port_idx_t'(k);
         w_dst = i_req_dst[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
         if (!rst && i_req_valid[w_idx]) begin
            if (w_dst == '0) begin
               // Zero mask: pop and discard, no output consumed.
               w_grant[w_idx] = 1'b1;
               w_n_drops      = w_n_drops + ONE_DROP;
            end else if (((w_dst & w_taken) == '0) &&
                         ((w_dst & ~i_out_ready) == '0)) begin
               // Whole mask free and ready: grant all destinations at once.
               w_grant[w_idx] = 1'b1;
               w_taken        = w_taken | w_dst;
               for (int o = 0; o < NUM_PORTS; o++) begin
                  if (w_dst[o]) begin
                     w_src[o] = w_idx;
                  end
               end
               if (!w_first_found) begin
                  w_first_found = 1'b1;
                  w_first_idx   = w_idx;
               end
            end
         end
      end
   end

   assign w_drop_sum = {1'b0, r_drop_cnt} +
                       {{(CNT_WIDTH - PORT_IDX_WIDTH){1'b0}}, w_n_drops};

   // --------------------------------------------------------------------------
   // Pointer and output registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr     <= '0;
         r_mux_sel    <= '0;
         r_out_active <= '0;
         r_drop_cnt   <= '0;
      end else begin
         r_out_active <= w_taken;
         r_mux_sel    <= w_src;
         // Pointer moves past the first real grant, starving or not.
         if (w_first_found) begin
            r_rr_ptr <= w_first_idx + port_idx_t'(1);
         end
         r_drop_cnt <= w_drop_sum[CNT_WIDTH] ? '1 : w_drop_sum[CNT_WIDTH-1:0];
      end
   end

   assign o_grant       = w_grant;
   assign o_mux_sel     = r_mux_sel;
   assign o_out_active  = r_out_active;
   assign o_starve_flag = w_starve_flag;
   assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_switch_sched_rr.sv
// -----------------------------------------------------------------------------
// tb_switch_sched_rr
// Self-checking bench for switch_sched_rr: a directed vector table, hand
// sequences for backpressure/starvation, zero-mask drops with saturation and
// asynchronous reset, then randomized traffic against a behavioural model.
// -----------------------------------------------------------------------------
module tb_switch_sched_rr;

   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [15:0] req_dst   = '0;
   logic [3:0]  out_ready = '0;
   logic [3:0]  grant;
   logic [7:0]  mux_sel;
   logic [3:0]  out_active;
   logic [3:0]  starve_flag;
   logic [15:0] drop_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   switch_sched_rr dut (
      .clk           (clk),
      .rst           (rst),
      .i_req_valid   (req_valid),
      .i_req_dst     (req_dst),
      .i_out_ready   (out_ready),
      .o_grant       (grant),
      .o_mux_sel     (mux_sel),
      .o_out_active  (out_active),
      .o_starve_flag (starve_flag),
      .o_drop_cnt    (drop_cnt)
   );

   // ---------------------------------------------------------------------------
   // Reference model: plain integers, scanned with modulo arithmetic.
   // ---------------------------------------------------------------------------
   int         m_ptr;
   int         m_wait[4];
   int         m_src[4];
   int         m_act[4];
   int         m_drop;
   logic [3:0] e_grant;
   int         e_taken;
   int         e_src[4];
   int         e_first;
   int         e_drops;

   function automatic void model_reset();
      m_ptr  = 0;
      m_drop = 0;
      for (int i = 0; i < 4; i++) begin
         m_wait[i] = 0;
         m_src[i]  = 0;
         m_act[i]  = 0;
      end
   endfunction

   function automatic void model_eval(input logic [3:0] v, input logic [15:0] d,
                                      input logic [3:0] r);
      int s;
      int i;
      int dst;
      s = m_ptr;
      for (int j = 3; j >= 0; j--) if (m_wait[j] == LIMIT) s = j;
      e_grant = '0;
      e_taken = 0;
      e_first = -1;
      e_drops = 0;
      for (int o = 0; o < 4; o++) e_src[o] = m_src[o];
      for (int k = 0; k < 4; k++) begin
         i   = (s + k) % 4;
         dst = int'((d >> (4 * i)) & 16'hF);
         if (v[i]) begin
            if (dst == 0) begin
               e_grant[i] = 1'b1;
               e_drops++;
            end else if ((dst & e_taken) == 0 && (dst & ~int'(r)) == 0) begin
               e_grant[i] = 1'b1;
               e_taken    = e_taken | dst;
               for (int o = 0; o < 4; o++) if ((dst >> o) & 1) e_src[o] = i;
               if (e_first < 0) e_first = i;
            end
         end
      end
   endfunction

   function automatic void model_commit(input logic [3:0] v);
      for (int o = 0; o < 4; o++) begin
         m_act[o] = (e_taken >> o) & 1;
         m_src[o] = e_src[o];
      end
      if (e_first >= 0) m_ptr = (e_first + 1) % 4;
      for (int i = 0; i < 4; i++) begin
         if (!v[i] || e_grant[i]) m_wait[i] = 0;
         else if (m_wait[i] < LIMIT) m_wait[i]++;
      end
      m_drop = (m_drop + e_drops > 65535) ? 65535 : m_drop + e_drops;
   endfunction

   function automatic logic [7:0] exp_mux();
      logic [7:0] x;
      for (int o = 0; o < 4; o++) x[2*o +: 2] = 2'(m_src[o]);
      return x;
   endfunction

   function automatic logic [3:0] exp_act();
      logic [3:0] x;
      for (int o = 0; o < 4; o++) x[o] = (m_act[o] != 0);
      return x;
   endfunction

   function automatic logic [3:0] exp_flags();
      logic [3:0] x;
      for (int i = 0; i < 4; i++) x[i] = (m_wait[i] == LIMIT);
      return x;
   endfunction

   // ---------------------------------------------------------------------------
   // Checking and stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Called just after a falling edge: drive, compare, clock, update model.
   task automatic step(input logic [3:0] v, input logic [15:0] d, input logic [3:0] r);
      req_valid = v;
      req_dst   = d;
      out_ready = r;
      #1;
      check("mux_sel", 32'(mux_sel), 32'(exp_mux()));
      check("out_active", 32'(out_active), 32'(exp_act()));
      check("starve_flag", 32'(starve_flag), 32'(exp_flags()));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      model_eval(v, d, r);
      check("grant", 32'(grant), 32'(e_grant));
      @(posedge clk);
      model_commit(v);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_dst   = '0;
      out_ready = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic [3:0]  v;
      logic [15:0] d;
      logic [3:0]  r;
      logic [3:0]  exp_grant;
      logic [3:0]  exp_act;
      logic [7:0]  exp_mux;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Contention on output 2 from rr_ptr=0, then unicast, then multicast.
      tbl[0] = '{4'hF, 16'h4444, 4'hF, 4'b0001, 4'b0100, 8'h00};
      tbl[1] = '{4'hF, 16'h4444, 4'hF, 4'b0010, 4'b0100, 8'h10};
      tbl[2] = '{4'hF, 16'h4444, 4'hF, 4'b0100, 4'b0100, 8'h20};
      tbl[3] = '{4'hF, 16'h4444, 4'hF, 4'b1000, 4'b0100, 8'h30};
      tbl[4] = '{4'hF, 16'h8421, 4'hF, 4'b1111, 4'b1111, 8'hE4};
      tbl[5] = '{4'h8, 16'h1000, 4'hF, 4'b1000, 4'b0001, 8'hE7};
      tbl[6] = '{4'h3, 16'h0064, 4'hF, 4'b0001, 4'b0100, 8'hC7};
      tbl[7] = '{4'h2, 16'h0060, 4'hF, 4'b0010, 4'b0110, 8'hD7};

      // Reset state, with requests present while reset is held.
      req_valid = 4'hF;
      req_dst   = 16'h4444;
      out_ready = 4'hF;
      #12;
      check("reset grant", 32'(grant), 32'h0);
      check("reset out_active", 32'(out_active), 32'h0);
      check("reset mux_sel", 32'(mux_sel), 32'h0);
      check("reset starve_flag", 32'(starve_flag), 32'h0);
      check("reset drop_cnt", 32'(drop_cnt), 32'h0);
      do_reset();

      // Directed table
      for (int n = 0; n < 8; n++) begin
         req_valid = tbl[n].v;
         req_dst   = tbl[n].d;
         out_ready = tbl[n].r;
         #1;
         model_eval(tbl[n].v, tbl[n].d, tbl[n].r);
         check($sformatf("tbl%0d grant", n), 32'(grant), 32'(tbl[n].exp_grant));
         @(posedge clk);
         model_commit(tbl[n].v);
         @(negedge clk);
         #1;
         check($sformatf("tbl%0d out_active", n), 32'(out_active), 32'(tbl[n].exp_act));
         check($sformatf("tbl%0d mux_sel", n), 32'(mux_sel), 32'(tbl[n].exp_mux));
      end

      // Backpressure on output 3 until every requester starves.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         req_valid = 4'hF;
         req_dst   = 16'h8888;
         out_ready = 4'b0111;
         #1;
         check("bp no grant", 32'(grant), 32'h0);
         if (c == 7) check("bp starve not yet", 32'(starve_flag), 32'h0);
         if (c == 8) check("bp starve set", 32'(starve_flag), 32'hF);
         step(4'hF, 16'h8888, 4'b0111);
      end
      out_ready = 4'hF;
      #1;
      check("starve first grant", 32'(grant), 32'b0001);
      step(4'hF, 16'h8888, 4'hF);
      #1;
      check("starve flag clears", 32'(starve_flag), 32'b1110);
      check("starve next grant", 32'(grant), 32'b0010);
      step(4'hF, 16'h8888, 4'hF);
      step(4'hF, 16'h8888, 4'hF);

      // Zero-mask drops and counter saturation.
      do_reset();
      for (int c = 0; c < 3; c++) begin
         req_valid = 4'b0100;
         req_dst   = 16'h0000;
         out_ready = 4'hF;
         #1;
         check("drop grant", 32'(grant), 32'b0100);
         step(4'b0100, 16'h0000, 4'hF);
      end
      #1;
      check("drop count 3", 32'(drop_cnt), 32'd3);
      check("drop out_active", 32'(out_active), 32'h0);
      force dut.r_drop_cnt = 16'hFFFF;
      #1;
      release dut.r_drop_cnt;
      m_drop = 65535;
      step(4'b0100, 16'h0000, 4'hF);
      #1;
      check("drop saturate", 32'(drop_cnt), 32'hFFFF);

      // Asynchronous reset in the middle of contention.
      do_reset();
      step(4'hF, 16'h4444, 4'hF);
      step(4'hF, 16'h4444, 4'hF);
      #2;
      rst = 1'b1;
      #1;
      check("async rst out_active", 32'(out_active), 32'h0);
      check("async rst mux_sel", 32'(mux_sel), 32'h0);
      check("async rst grant", 32'(grant), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      check("post rst first grant", 32'(grant), 32'b0001);
      step(4'hF, 16'h4444, 4'hF);
      step(4'hF, 16'h4444, 4'hF);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         logic [3:0]  v;
         logic [15:0] d;
         logic [3:0]  r;
         v = 4'($urandom) | 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            d[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         end
         r = (c < 300) ? (4'($urandom) | 4'($urandom)) : 4'($urandom);
         step(v, d, r);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
